// File: rtl/axi_line_refill.sv
// axi_line_refill: client-side read sequencer for cache refills.
// It takes one single-word or full-line request from a miss handler and issues it
// on the shim's rd_* request handshake. It collects the returned beats into a line
// buffer and reports the finished line with a one-cycle valid pulse.
// Only one transaction is in flight at a time.
module axi_line_refill #(
  parameter int AxiNumWords = 4,
  parameter int AxiIdWidth  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // client request side
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [63:0]                 addr_i,
  input  logic                        single_i,
  input  logic [1:0]                  size_i,
  input  logic                        instr_i,
  input  logic [AxiIdWidth-1:0]       id_i,
  output logic                        busy_o,
  output logic                        valid_o,
  output logic [AxiNumWords*64-1:0]   line_o,
  output logic                        exokay_o,
  // shim read channel
  output logic                        rd_req_o,
  input  logic                        rd_gnt_i,
  output logic [63:0]                 rd_addr_o,
  output logic [$clog2(AxiNumWords)-1:0] rd_blen_o,
  output logic [1:0]                  rd_size_o,
  output logic [AxiIdWidth-1:0]       rd_id_o,
  output logic                        rd_lock_o,
  output logic                        rd_instr_o,
  output logic                        rd_rdy_o,
  input  logic                        rd_valid_i,
  input  logic                        rd_last_i,
  input  logic [63:0]                 rd_data_i,
  input  logic [AxiIdWidth-1:0]       rd_id_i,
  input  logic                        rd_exokay_i
);

  localparam int Lw = $clog2(AxiNumWords);
  localparam logic [Lw-1:0] LAST_IDX = Lw'(AxiNumWords - 1);
  // Clears the byte-in-line offset so line reads start on a line boundary.
  localparam logic [63:0] LINE_MASK = ~((64'd1 << (Lw + 3)) - 64'd1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [63:0]           r_addr;
  logic [Lw-1:0]         r_blen;
  logic [1:0]            r_size;
  logic [AxiIdWidth-1:0] r_id;
  logic                  r_instr;
  logic                  r_single;
  logic [Lw-1:0]         r_widx;
  logic [Lw-1:0]         r_cnt;
  logic                  r_exok_acc;
  logic                  r_exokay;
  logic [63:0]           r_line [AxiNumWords];

  logic                  w_accept;
  logic [Lw-1:0]         w_wr_idx;

  // A beat counts only in RESP and only if it carries our ID. Any other beat is sunk.
  assign w_accept = (r_state == ST_RESP) && rd_valid_i && (rd_id_i == r_id);
  // A single read targets its addressed word. A line read fills the words in order.
  assign w_wr_idx = r_single ? r_widx : r_cnt;

  assign gnt_o      = (r_state == ST_IDLE) && req_i;
  assign busy_o     = (r_state != ST_IDLE);
  assign valid_o    = (r_state == ST_DONE);
  assign exokay_o   = r_exokay;
  assign rd_req_o   = (r_state == ST_REQ);
  assign rd_rdy_o   = (r_state == ST_RESP);
  assign rd_addr_o  = r_addr;
  assign rd_blen_o  = r_blen;
  assign rd_size_o  = r_size;
  assign rd_id_o    = r_id;
  assign rd_instr_o = r_instr;
  assign rd_lock_o  = 1'b0;

  // Control FSM: request capture, handshake sequencing, beat counting, exokay accumulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_blen     <= '0;
      r_size     <= '0;
      r_id       <= '0;
      r_instr    <= 1'b0;
      r_single   <= 1'b0;
      r_widx     <= '0;
      r_cnt      <= '0;
      r_exok_acc <= 1'b0;
      r_exokay   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_addr     <= single_i ? addr_i : (addr_i & LINE_MASK);
            r_blen     <= single_i ? '0 : LAST_IDX;
            r_size     <= single_i ? size_i : 2'd3;
            r_id       <= id_i;
            r_instr    <= instr_i;
            r_single   <= single_i;
            r_widx     <= addr_i[Lw+2:3];
            r_cnt      <= '0;
            r_exok_acc <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_gnt_i) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_accept) begin
            r_exok_acc <= r_exok_acc & rd_exokay_i;
            // The count saturates on the last word, so overlong bursts keep overwriting it.
            if (r_cnt != LAST_IDX) begin
              r_cnt <= r_cnt + 1'b1;
            end
            // The shim's last flag ends the burst, whatever the count has reached.
            if (rd_last_i) begin
              r_exokay <= r_exok_acc & rd_exokay_i;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < AxiNumWords; gi++) begin : g_word
      // Line buffer word gi: written by accepted beats aimed at it, kept otherwise.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_line[gi] <= '0;
        end else if (w_accept && (w_wr_idx == Lw'(gi))) begin
          r_line[gi] <= rd_data_i;
        end
      end
      assign line_o[64*gi +: 64] = r_line[gi];
    end
  endgenerate

endmodule
